// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per start, LSB first, sampled on rising sck.
// cont holds ss low across bytes so multi-byte frames share one select.
module spi_master #(
    parameter int CLK_DIV = 25,
    localparam int CNT_W = $clog2(CLK_DIV + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic [7:0] tx_data,
    input  logic       miso,
    output logic       sck,
    output logic       ss,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        TAIL
    } state_t;

    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PH_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] phase_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       tx_sh_q;
    logic [7:0]       rx_sh_q;
    logic             cont_q;
    logic             sck_q;
    logic             ss_q;
    logic             mosi_q;
    logic [7:0]       rx_data_q;
    logic             busy_q;
    logic             done_q;

    logic             ph_end;
    logic [2:0]       bit_nxt_d;

    always_comb begin
        ph_end    = (phase_q == PH_LAST);
        bit_nxt_d = bit_cnt_q + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            cont_q    <= 1'b0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    sck_q <= 1'b0;
                    if (start) begin
                        tx_sh_q   <= tx_data;
                        cont_q    <= cont;
                        bit_cnt_q <= '0;
                        phase_q   <= '0;
                        busy_q    <= 1'b1;
                        ss_q      <= 1'b0;
                        mosi_q    <= tx_data[0];
                        // ss still low from a cont byte: skip the lead time
                        state_q   <= ss_q ? SETUP : LOW;
                    end
                end
                SETUP: begin
                    if (ph_end) begin
                        phase_q <= '0;
                        state_q <= LOW;
                    end else begin
                        phase_q <= phase_q + PH_ONE;
                    end
                end
                LOW: begin
                    if (ph_end) begin
                        phase_q            <= '0;
                        sck_q              <= 1'b1;
                        rx_sh_q[bit_cnt_q] <= miso;
                        state_q            <= HIGH;
                    end else begin
                        phase_q <= phase_q + PH_ONE;
                    end
                end
                HIGH: begin
                    if (ph_end) begin
                        phase_q <= '0;
                        sck_q   <= 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= TAIL;
                        end else begin
                            bit_cnt_q <= bit_nxt_d;
                            mosi_q    <= tx_sh_q[bit_nxt_d];
                            state_q   <= LOW;
                        end
                    end else begin
                        phase_q <= phase_q + PH_ONE;
                    end
                end
                TAIL: begin
                    if (ph_end) begin
                        phase_q   <= '0;
                        rx_data_q <= rx_sh_q;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        ss_q      <= ~cont_q;
                        state_q   <= IDLE;
                    end else begin
                        phase_q <= phase_q + PH_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sck     = sck_q;
    assign ss      = ss_q;
    assign mosi    = mosi_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master that generates sck/ss/mosi and samples miso. It is the upstream stage that drives the team's `spi` slave block.
- Transfers one byte per `start`, LSB first. Data changes while sck is low; both ends sample on the rising sck edge.
- The optional `cont` flag holds ss low across consecutive bytes, so multi-byte frames are possible.
- Sits between a host-side controller (tx_data/start, rx_data/done) and the SPI pins.

Parameters:
- CLK_DIV, 25: sck half-period in clk cycles. Legal range is ≥2; 25 gives 500 ns at a 20 ns clk.
- CNT_W, $clog2(CLK_DIV+1): width of the phase counter. Derived; never overridden.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request; accepted only when busy=0.
- cont  input  1  sampled with start. 1 = keep ss low after this byte.
- tx_data  input  8  byte to send, latched on accept.
- miso  input  1  serial data from the slave.
- sck  output  1  serial clock, idles 0.
- ss  output  1  slave select, active-low, idles 1.
- mosi  output  1  serial data to the slave.
- rx_data  output  8  last received byte; valid from done onward.
- busy  output  1  high from the cycle after accept until the done cycle (exclusive).
- done  output  1  one-cycle pulse when a byte completes.

Behaviour:
- Reset (async, any state):
  - state=IDLE; outputs sck=0, ss=1, mosi=0, rx_data=0, busy=0, done=0.
  - Bit counter, phase counter, shift registers and held-cont flag all clear.
- States: IDLE, SETUP, LOW, HIGH, TAIL. All outputs are registered.
- IDLE:
  - busy=0, sck=0; ss keeps its current value.
  - On start: latch tx_data into tx_sh, latch cont, set bit_cnt=0, phase_cnt=0, busy=1, ss=0, mosi=tx_data[0].
  - Next state is SETUP if ss was 1, otherwise LOW (ss already held by a previous cont byte).
- SETUP: lasts CLK_DIV cycles (ss-to-first-edge lead), then LOW.
- LOW:
  - sck=0, mosi=tx_sh[bit_cnt]. Lasts CLK_DIV cycles.
  - On the exit edge: sck←1 and rx_sh[bit_cnt]←miso; go to HIGH.
- HIGH:
  - sck=1. Lasts CLK_DIV cycles.
  - On the exit edge: sck←0.
  - If bit_cnt=7, go to TAIL; else bit_cnt+1, mosi←next bit, go to LOW.
- TAIL:
  - sck=0. Lasts CLK_DIV cycles (hold after the last fall).
  - On the exit edge: rx_data←rx_sh, done←1, busy←0, ss←~cont_held; go to IDLE.
- done is high exactly one cycle, coincident with the first IDLE cycle.
- Latency, start edge to done cycle:
  - 18·CLK_DIV+1 cycles when ss starts high.
  - 17·CLK_DIV+1 cycles when ss is already low.
  - At CLK_DIV=25 these are 451 and 426.
- Exactly 8 rising sck edges per byte. sck never toggles in IDLE/SETUP/TAIL.
- start while busy=1 is ignored; no queueing.
- start in the done cycle is accepted, because busy=0 there.
- tx_data/cont changes after accept have no effect on the current byte.
- miso is sampled only at LOW→HIGH edges; miso activity elsewhere is ignored.
- rx_data holds its value between done pulses.
- ss is held low indefinitely after a cont=1 byte until a byte with cont=0 completes.
- Reset mid-byte drives ss=1 and sck=0 immediately, truncating the frame. The next start behaves as from power-up.

Test Plan:
1. Reset for 10 cycles, then idle 20 cycles -> sck=0, ss=1, mosi=0, busy=0, done=0, rx_data=00 throughout.
2. Loop back to the `spi` slave with slave dout=3C; start tx=AA, cont=0 -> done exactly once, 451 cycles after the start edge.
   - rx_data=3C; slave din=AA.
   - 8 sck rises; ss returns to 1 in the done cycle.
3. Three bytes with cont=1,1,0: tx FF, 00, BE against slave dout AA, FF, 00.
   - rx_data = AA, FF, 00 in turn; slave din = FF, 00, BE.
   - ss stays low continuously from first accept to the third done.
   - Second and third done arrive 426 cycles after their starts.
4. Send tx=01 -> mosi=1 only during the first bit window; mosi stable across every rising sck.
   - Send tx=80 -> mosi=1 only in the last window (LSB-first check).
5. Pulse start with tx=55 at cycles +5 and +200 after a first start with tx=AA -> only AA is sent.
   - A start in the done cycle with tx=55 is accepted; busy goes to 1 on the next cycle.
6. Assert rst after the 3rd sck rise of a byte -> sck=0 and ss=1 within the same cycle, done never pulses.
   - A subsequent start with tx=C3 completes normally; the slave receives C3.
